// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue front end: datapath width,
// ALU op codes, latency counter width and FSM state encoding.
package alu_pkg;

    localparam int ALU_WIDTH = 16;
    localparam int CNT_W     = 4;

    localparam logic [2:0] OP_PASSA = 3'b000;
    localparam logic [2:0] OP_NOTA  = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_NEGA  = 3'b110;
    localparam logic [2:0] OP_NEGB  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issuer_if.sv
// Request, ALU-side and response signals of the ALU issuer.
// slave is the issuer's view; master is the requester/consumer/ALU side.
interface alu_issuer_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             req_inm;
    logic             req_setz;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic             alu_s_inm;
    logic [WIDTH-1:0] alu_y;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_y;
    logic             rsp_zero;
    logic             z_flag;
    logic             err_zero;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_inm, req_setz,
        input  alu_y, alu_zero, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op, alu_s_inm,
        output rsp_valid, rsp_y, rsp_zero, z_flag, err_zero
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_inm, req_setz,
        output alu_y, alu_zero, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op, alu_s_inm,
        input  rsp_valid, rsp_y, rsp_zero, z_flag, err_zero
    );

endinterface

// File: rtl/alu_issuer.sv
// Sequential front end for the combinational ALU: registers a request onto the
// ALU inputs, waits ALU_LAT cycles, captures the result and hands it back.
module alu_issuer
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    alu_issuer_if.slave bus
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_op;
    logic             r_alu_s_inm;
    logic             r_setz;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_y;
    logic             r_rsp_zero;
    logic             r_z_flag;
    logic             r_err_zero;

    logic w_req_ready;
    logic w_accept;
    logic w_capture;
    logic w_y_is_zero;

    // Ready is masked by reset so it reads 0 throughout the reset cycle.
    assign w_req_ready = !reset && ((r_state == ST_IDLE) ||
                                    ((r_state == ST_RESP) && bus.rsp_ready));
    assign w_accept    = w_req_ready && bus.req_valid;
    assign w_capture   = (r_state == ST_EXEC) && (r_cnt == '0);
    assign w_y_is_zero = ~|bus.alu_y;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: operand registers are reset too, so the ALU inputs read 0
            // after reset instead of stale or unknown values.
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_alu_s_inm <= 1'b0;
            r_setz      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_y     <= '0;
            r_rsp_zero  <= 1'b0;
            r_z_flag    <= 1'b0;
            r_err_zero  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a     <= bus.req_a;
                r_alu_b     <= bus.req_b;
                r_alu_op    <= bus.req_op;
                r_alu_s_inm <= bus.req_inm;
                r_setz      <= bus.req_setz;
                r_cnt       <= LAT_LOAD;
            end else if ((r_state == ST_EXEC) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (w_capture) begin
                r_rsp_y    <= bus.alu_y;
                r_rsp_zero <= bus.alu_zero;
                if (r_setz) r_z_flag <= bus.alu_zero;
                if (bus.alu_zero != w_y_is_zero) r_err_zero <= 1'b1;
            end

            case (r_state)
                ST_IDLE: if (w_accept) r_state <= ST_EXEC;
                ST_EXEC: begin
                    if (w_capture) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= bus.req_valid ? ST_EXEC : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_op    = r_alu_op;
    assign bus.alu_s_inm = r_alu_s_inm;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_y     = r_rsp_y;
    assign bus.rsp_zero  = r_rsp_zero;
    assign bus.z_flag    = r_z_flag;
    assign bus.err_zero  = r_err_zero;

endmodule

// File: tb/tb_alu_issuer.sv
// Bench for alu_issuer: two instances (ALU_LAT=1 and ALU_LAT=3) driven by
// directed ops, checked every cycle against a transaction-timed model.
module tb_alu_issuer;
    import alu_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        d_valid [2];
    logic [2:0]  d_op [2];
    logic [15:0] d_a [2];
    logic [15:0] d_b [2];
    logic        d_inm [2];
    logic        d_setz [2];
    logic        d_rsp_ready [2];
    logic        fault [2];

    logic        o_req_ready [2];
    logic        o_rsp_valid [2];
    logic [15:0] o_rsp_y [2];
    logic        o_rsp_zero [2];
    logic        o_z [2];
    logic        o_err [2];
    logic [15:0] o_alu_a [2];
    logic [15:0] o_alu_b [2];
    logic [2:0]  o_alu_op [2];
    logic        o_alu_inm [2];

    int n_checks = 0;
    int n_errors = 0;
    int now = 0;
    int lat_of [2] = '{1, 3};

    // Behavioural stand-in for the datapath ALU.
    function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic inm);
        case (op)
            OP_PASSA: return a;
            OP_NOTA:  return ~a;
            OP_ADD:   return a + b;
            OP_SUB:   return inm ? (b - a) : (a - b);
            OP_AND:   return a & b;
            OP_OR:    return a | b;
            OP_NEGA:  return -a;
            default:  return -b;
        endcase
    endfunction

    alu_issuer_if #(.WIDTH(W)) bus1 ();
    alu_issuer_if #(.WIDTH(W)) bus3 ();

    alu_issuer #(.WIDTH(W), .ALU_LAT(1)) dut1 (.clk(clk), .reset(rst[0]), .bus(bus1.slave));
    alu_issuer #(.WIDTH(W), .ALU_LAT(3)) dut3 (.clk(clk), .reset(rst[1]), .bus(bus3.slave));

    assign bus1.req_valid = d_valid[0];
    assign bus1.req_op    = d_op[0];
    assign bus1.req_a     = d_a[0];
    assign bus1.req_b     = d_b[0];
    assign bus1.req_inm   = d_inm[0];
    assign bus1.req_setz  = d_setz[0];
    assign bus1.rsp_ready = d_rsp_ready[0];
    assign bus1.alu_y     = alu_f(bus1.alu_op, bus1.alu_a, bus1.alu_b, bus1.alu_s_inm);
    assign bus1.alu_zero  = fault[0] | (bus1.alu_y == 16'h0000);

    assign bus3.req_valid = d_valid[1];
    assign bus3.req_op    = d_op[1];
    assign bus3.req_a     = d_a[1];
    assign bus3.req_b     = d_b[1];
    assign bus3.req_inm   = d_inm[1];
    assign bus3.req_setz  = d_setz[1];
    assign bus3.rsp_ready = d_rsp_ready[1];
    assign bus3.alu_y     = alu_f(bus3.alu_op, bus3.alu_a, bus3.alu_b, bus3.alu_s_inm);
    assign bus3.alu_zero  = fault[1] | (bus3.alu_y == 16'h0000);

    assign o_req_ready[0] = bus1.req_ready;  assign o_req_ready[1] = bus3.req_ready;
    assign o_rsp_valid[0] = bus1.rsp_valid;  assign o_rsp_valid[1] = bus3.rsp_valid;
    assign o_rsp_y[0]     = bus1.rsp_y;      assign o_rsp_y[1]     = bus3.rsp_y;
    assign o_rsp_zero[0]  = bus1.rsp_zero;   assign o_rsp_zero[1]  = bus3.rsp_zero;
    assign o_z[0]         = bus1.z_flag;     assign o_z[1]         = bus3.z_flag;
    assign o_err[0]       = bus1.err_zero;   assign o_err[1]       = bus3.err_zero;
    assign o_alu_a[0]     = bus1.alu_a;      assign o_alu_a[1]     = bus3.alu_a;
    assign o_alu_b[0]     = bus1.alu_b;      assign o_alu_b[1]     = bus3.alu_b;
    assign o_alu_op[0]    = bus1.alu_op;     assign o_alu_op[1]    = bus3.alu_op;
    assign o_alu_inm[0]   = bus1.alu_s_inm;  assign o_alu_inm[1]   = bus3.alu_s_inm;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each accepted op is due at a fixed time stamp (accept edge + ALU_LAT);
    // it is presented from then until popped by rsp_ready.
    typedef struct {
        logic [15:0] y;
        logic        zero;
        logic        setz;
        logic        ferr;
        int          t;
    } exp_t;

    exp_t        q [2][$];
    logic        m_z [2];
    logic        m_err [2];
    logic        m_live [2] = '{1'b0, 1'b0};
    logic [15:0] m_la [2];
    logic [15:0] m_lb [2];
    logic [2:0]  m_lop [2];
    logic        m_linm [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic fr;
            logic er;
            exp_t e;
            fr = (q[i].size() > 0) && (q[i][0].t <= now);
            er = !rst[i] && ((q[i].size() == 0) || (fr && d_rsp_ready[i]));
            if (m_live[i]) begin
                check($sformatf("i%0d req_ready", i), 32'(o_req_ready[i]), 32'(er));
                check($sformatf("i%0d rsp_valid", i), 32'(o_rsp_valid[i]), 32'(fr));
                if (fr) begin
                    check($sformatf("i%0d rsp_y", i), 32'(o_rsp_y[i]), 32'(q[i][0].y));
                    check($sformatf("i%0d rsp_zero", i), 32'(o_rsp_zero[i]), 32'(q[i][0].zero));
                end
                check($sformatf("i%0d z_flag", i), 32'(o_z[i]), 32'(m_z[i]));
                check($sformatf("i%0d err_zero", i), 32'(o_err[i]), 32'(m_err[i]));
                check($sformatf("i%0d alu_a", i), 32'(o_alu_a[i]), 32'(m_la[i]));
                check($sformatf("i%0d alu_b", i), 32'(o_alu_b[i]), 32'(m_lb[i]));
                check($sformatf("i%0d alu_op", i), 32'(o_alu_op[i]), 32'(m_lop[i]));
                check($sformatf("i%0d alu_s_inm", i), 32'(o_alu_inm[i]), 32'(m_linm[i]));
            end
            if (rst[i]) begin
                q[i].delete();
                m_z[i] = 1'b0;  m_err[i] = 1'b0;
                m_la[i] = '0;   m_lb[i] = '0;  m_lop[i] = '0;  m_linm[i] = 1'b0;
                m_live[i] = 1'b1;
            end else if (m_live[i]) begin
                if ((q[i].size() > 0) && (q[i][0].t == now + 1)) begin
                    if (q[i][0].setz) m_z[i] = q[i][0].zero;
                    if (q[i][0].ferr) m_err[i] = 1'b1;
                end
                if (fr && d_rsp_ready[i]) void'(q[i].pop_front());
                if (er && d_valid[i]) begin
                    e.y    = alu_f(d_op[i], d_a[i], d_b[i], d_inm[i]);
                    e.zero = fault[i] | (e.y == 16'h0000);
                    e.ferr = e.zero != (e.y == 16'h0000);
                    e.setz = d_setz[i];
                    e.t    = now + 1 + lat_of[i];
                    q[i].push_back(e);
                    m_la[i] = d_a[i];  m_lb[i] = d_b[i];  m_lop[i] = d_op[i];  m_linm[i] = d_inm[i];
                end
            end
        end
        now++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int i, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic inm, input logic setz);
        int n;
        d_op[i] = op;  d_a[i] = a;  d_b[i] = b;  d_inm[i] = inm;  d_setz[i] = setz;
        d_valid[i] = 1'b1;
        #1;
        n = 0;
        while (!o_req_ready[i] && n < 50) begin
            tick();
            #1;
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL i%0d accept: req_ready never rose", i);
        end
        tick();
        d_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int i, input string name, input logic [15:0] y,
                            input logic zero, input logic z, input int exp_lat);
        int n;
        n = 0;
        while (!o_rsp_valid[i] && n < 50) begin
            tick();
            n++;
        end
        check({name, " latency"}, n, exp_lat);
        check({name, " y"}, 32'(o_rsp_y[i]), 32'(y));
        check({name, " zero"}, 32'(o_rsp_zero[i]), 32'(zero));
        check({name, " z_flag"}, 32'(o_z[i]), 32'(z));
    endtask

    task automatic pop(input int i);
        d_rsp_ready[i] = 1'b1;
        tick();
        d_rsp_ready[i] = 1'b0;
    endtask

    task automatic run_op(input int i, input string name, input logic [2:0] op,
                          input logic [15:0] a, input logic [15:0] b, input logic inm,
                          input logic setz, input logic [15:0] y, input logic zero,
                          input logic z);
        issue(i, op, a, b, inm, setz);
        wait_rsp(i, name, y, zero, z, lat_of[i]);
        pop(i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1;  d_valid[i] = 1'b0;  d_op[i] = '0;  d_a[i] = '0;  d_b[i] = '0;
            d_inm[i] = 1'b0;  d_setz[i] = 1'b0;  d_rsp_ready[i] = 1'b0;  fault[i] = 1'b0;
        end
        tick();
        tick();
        check("reset req_ready", 32'(o_req_ready[0]), 32'h0);
        check("reset rsp_valid", 32'(o_rsp_valid[0]), 32'h0);
        check("reset z_flag", 32'(o_z[0]), 32'h0);
        check("reset err_zero", 32'(o_err[0]), 32'h0);
        rst[0] = 1'b0;
        #1;
        check("post-reset req_ready", 32'(o_req_ready[0]), 32'h1);

        run_op(0, "add",   OP_ADD,  16'h0003, 16'h0004, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b0);
        run_op(0, "sub0",  OP_SUB,  16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
        run_op(0, "or",    OP_OR,   16'h00F0, 16'h000F, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b1);
        run_op(0, "subr",  OP_SUB,  16'h0001, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1);
        run_op(0, "negb",  OP_NEGB, 16'h1234, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op(0, "nota",  OP_NOTA, 16'h00FF, 16'h0000, 1'b0, 1'b0, 16'hFF00, 1'b0, 1'b1);
        run_op(0, "nega",  OP_NEGA, 16'h0001, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1);

        // Backpressure: response must hold for 5 cycles with req_ready low.
        issue(0, OP_AND, 16'hFF0F, 16'h0FF0, 1'b0, 1'b0);
        wait_rsp(0, "and", 16'h0F00, 1'b0, 1'b1, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp rsp_valid", 32'(o_rsp_valid[0]), 32'h1);
            check("bp rsp_y", 32'(o_rsp_y[0]), 32'h0F00);
            check("bp req_ready", 32'(o_req_ready[0]), 32'h0);
        end

        // Back-to-back: pop and accept on the same edge.
        d_op[0] = OP_ADD;  d_a[0] = 16'h0001;  d_b[0] = 16'h0001;  d_inm[0] = 1'b0;  d_setz[0] = 1'b1;
        d_valid[0] = 1'b1;
        d_rsp_ready[0] = 1'b1;
        #1;
        check("b2b req_ready", 32'(o_req_ready[0]), 32'h1);
        tick();
        d_valid[0] = 1'b0;
        d_rsp_ready[0] = 1'b0;
        check("b2b rsp_valid drop", 32'(o_rsp_valid[0]), 32'h0);
        wait_rsp(0, "b2b", 16'h0002, 1'b0, 1'b0, 1);
        pop(0);

        // Faulty ALU zero flag at capture sets the sticky error.
        fault[0] = 1'b1;
        run_op(0, "fault", OP_PASSA, 16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0);
        fault[0] = 1'b0;
        check("err set", 32'(o_err[0]), 32'h1);
        run_op(0, "good",  OP_ADD,  16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0);
        check("err sticky", 32'(o_err[0]), 32'h1);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        check("err cleared", 32'(o_err[0]), 32'h0);

        // ALU_LAT = 3 instance.
        rst[1] = 1'b0;
        tick();
        run_op(1, "l3 sub", OP_SUB, 16'h0007, 16'h0007, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
        issue(1, OP_ADD, 16'h1234, 16'h0001, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check("l3 hold alu_a", 32'(o_alu_a[1]), 32'h1234);
            check("l3 hold alu_b", 32'(o_alu_b[1]), 32'h0001);
            check("l3 hold alu_op", 32'(o_alu_op[1]), 32'(OP_ADD));
            check("l3 hold rsp_valid", 32'(o_rsp_valid[1]), 32'h0);
            if (k < 2) tick();
        end
        wait_rsp(1, "l3 add", 16'h1235, 1'b0, 1'b1, 1);
        pop(1);

        // Reset during the second EXEC cycle discards the op.
        issue(1, OP_AND, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
        tick();
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        check("l3 rst z_flag", 32'(o_z[1]), 32'h0);
        check("l3 rst rsp_valid", 32'(o_rsp_valid[1]), 32'h0);
        for (int k = 0; k < 5; k++) tick();
        check("l3 no rsp", 32'(o_rsp_valid[1]), 32'h0);
        check("l3 idle ready", 32'(o_req_ready[1]), 32'h1);

        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_issuer.md
Name: alu_issuer

Overview:
Sequential front end that drives the datapath ALU (16-bit, 3-bit op_alu, s_inm modifier, zero flag). It accepts operation requests over a valid/ready handshake and presents registered operands and op to the ALU. It holds them for ALU_LAT cycles, then captures y/zero into a response register. It returns the result over a second valid/ready handshake and maintains an architectural Z flag plus a sticky consistency error.

Parameters:
WIDTH, 16, datapath width of operands and result
ALU_LAT, 1, cycles operands are held before capture (1..15; allows a multicycle ALU path)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept request this cycle
req_op  in  3  ALU operation code
req_a  in  WIDTH  operand A
req_b  in  WIDTH  operand B
req_inm  in  1  s_inm modifier (op 011: 1 = b-a, 0 = a-b)
req_setz  in  1  update Z flag with this result
alu_a  out  WIDTH  registered operand A to ALU
alu_b  out  WIDTH  registered operand B to ALU
alu_op  out  3  registered op to ALU
alu_s_inm  out  1  registered modifier to ALU
alu_y  in  WIDTH  ALU result
alu_zero  in  1  ALU zero flag
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_y  out  WIDTH  captured result
rsp_zero  out  1  captured zero
z_flag  out  1  architectural zero flag
err_zero  out  1  sticky: alu_zero disagreed with NOR-reduction of alu_y at capture

Behaviour:
- Reset (sync, high): state IDLE; all outputs 0 (req_ready=0 during reset cycle, 1 in first cycle after); cnt=0; err_zero=0; z_flag=0.
- Op encoding (alu_op): 000 pass a, 001 not a, 010 a+b, 011 a-b / b-a (s_inm), 100 and, 101 or, 110 -a, 111 -b. Arithmetic mod 2^WIDTH; no carry/overflow.
- States: IDLE, EXEC, RESP.
- IDLE: req_ready=1. On req_valid: latch req_* into alu_* regs and setz reg; cnt<=ALU_LAT-1; go EXEC.
- EXEC: req_ready=0; alu_* held stable. If cnt==0: capture rsp_y<=alu_y, rsp_zero<=alu_zero; if setz then z_flag<=alu_zero; if alu_zero != ~|alu_y then err_zero<=1; go RESP. Else cnt<=cnt-1.
- RESP: rsp_valid=1; rsp_y/rsp_zero stable until accepted. req_ready = rsp_ready (back-to-back).
  - rsp_ready and req_valid: new request latched, go EXEC.
  - rsp_ready only: go IDLE.
  - Otherwise: hold.
- Latency: request accepted at edge T -> rsp_valid high in cycle T+ALU_LAT+1. Throughput 1 op per ALU_LAT+1 cycles with back-to-back handshakes.
- alu_* outputs retain last values in IDLE/RESP (no glitching to 0); ALU combinational output is ignored except at capture.
- z_flag changes only on capture with setz=1; it is not cleared by a response handshake.
- err_zero is cleared only by reset.
- Reset in mid-EXEC or RESP: pending op is discarded, no response emitted, z_flag=0.
- req_valid while req_ready=0: ignored; the requester must hold it.

Decomposition:
- Shared package alu_pkg: op code localparams (OP_PASSA, OP_NOTA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NEGA, OP_NEGB), WIDTH default 16, state encodings.
- No sub-module required. The bench instantiates the existing ALU between alu_* and alu_y/alu_zero.

Test Plan:
- Reset, then ADD a=0x0003 b=0x0004 setz=1, ALU_LAT=1 -> rsp_valid two cycles after accept, rsp_y=0x0007, rsp_zero=0, z_flag=0.
- SUB a=0x0005 b=0x0005 inm=0 setz=1 -> rsp_y=0x0000, rsp_zero=1, z_flag=1. Then OR 0x00F0|0x000F setz=0 -> rsp_y=0x00FF, z_flag stays 1.
- SUB inm=1 a=0x0001 b=0x0000 -> rsp_y=0xFFFF (wrap). NEGB b=0x8000 -> 0x8000.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_y stable, req_ready=0. Then rsp_ready=1 with req_valid=1 -> next op accepted same cycle, no bubble.
- ALU_LAT=3: alu_a/alu_b/alu_op stable for 3 EXEC cycles, response at T+4. Reset asserted in second EXEC cycle -> no rsp_valid, z_flag=0.
- Fault injection: force alu_zero=1 with alu_y=0x0001 at capture -> err_zero=1 and stays 1 through later good ops until reset.
